// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined integer ALU (shift/add/logic/compare).
// Ports: CLK, nRST (async low), req_* request channel in, resp_* result channel out.
// Optional resp_err output: define ALU_PIPE_ILLEGAL_OP_ERR_EN to enable it.
module alu_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_A,
    input  logic [DATA_W-1:0] req_B,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_out,
    output logic [TAG_W-1:0]  resp_tag
`ifdef ALU_PIPE_ILLEGAL_OP_ERR_EN
    ,
    output logic              resp_err
`endif
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;

    logic              s0_valid_q, s0_valid_d;
    logic [3:0]        s0_op_q, s0_op_d;
    logic [DATA_W-1:0] s0_a_q, s0_a_d;
    logic [DATA_W-1:0] s0_b_q, s0_b_d;
    logic [TAG_W-1:0]  s0_tag_q, s0_tag_d;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_res_q, s1_res_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic              s1_adv;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_res;

    // S1 can take a new result when empty or when its result leaves now;
    // S0 can then move up, so req_ready depends on resp_ready only.
    assign s1_adv    = !s1_valid_q || resp_ready;
    assign req_ready = !s0_valid_q || s1_adv;
    assign shamt     = s0_b_q[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        unique case (s0_op_q)
            OP_SLL:  alu_res = s0_a_q << shamt;
            OP_SRL:  alu_res = s0_a_q >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(s0_a_q) >>> shamt);
            OP_ADD:  alu_res = s0_a_q + s0_b_q;
            OP_SUB:  alu_res = s0_a_q - s0_b_q;
            OP_AND:  alu_res = s0_a_q & s0_b_q;
            OP_OR:   alu_res = s0_a_q | s0_b_q;
            OP_XOR:  alu_res = s0_a_q ^ s0_b_q;
            OP_SLT:  alu_res[0] = $signed(s0_a_q) < $signed(s0_b_q);
            OP_SLTU: alu_res[0] = s0_a_q < s0_b_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_op_d    = s0_op_q;
        s0_a_d     = s0_a_q;
        s0_b_d     = s0_b_q;
        s0_tag_d   = s0_tag_q;
        if (req_ready) begin
            s0_valid_d = req_valid;
            if (req_valid) begin
                s0_op_d  = req_op;
                s0_a_d   = req_A;
                s0_b_d   = req_B;
                s0_tag_d = req_tag;
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_res_d   = s1_res_q;
        s1_tag_d   = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d = s0_valid_q;
            if (s0_valid_q) begin
                s1_res_d = alu_res;
                s1_tag_d = s0_tag_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s0_valid_q <= 1'b0;
            s0_op_q    <= '0;
            s0_a_q     <= '0;
            s0_b_q     <= '0;
            s0_tag_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_tag_q   <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_op_q    <= s0_op_d;
            s0_a_q     <= s0_a_d;
            s0_b_q     <= s0_b_d;
            s0_tag_q   <= s0_tag_d;
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s1_tag_q   <= s1_tag_d;
        end
    end

    assign resp_valid = s1_valid_q;
    assign resp_out   = s1_res_q;
    assign resp_tag   = s1_tag_q;

`ifdef ALU_PIPE_ILLEGAL_OP_ERR_EN
    logic alu_err;
    logic s1_err_q, s1_err_d;

    assign alu_err = !((s0_op_q <= OP_XOR) ||
                       (s0_op_q == OP_SLT) ||
                       (s0_op_q == OP_SLTU));

    always_comb begin
        s1_err_d = s1_err_q;
        if (s1_adv && s0_valid_q) begin
            s1_err_d = alu_err;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_err_q <= 1'b0;
        end else begin
            s1_err_q <= s1_err_d;
        end
    end

    assign resp_err = s1_err_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized + directed self-checking bench for alu_pipe.
// Reference model is an in-order queue of accepted requests with their results.
module tb_alu_pipe;

    localparam int DW = 32;
    localparam int TW = 4;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          req_valid = 1'b0;
    logic [3:0]    req_op = '0;
    logic [DW-1:0] req_A = '0;
    logic [DW-1:0] req_B = '0;
    logic [TW-1:0] req_tag = '0;
    logic          resp_ready = 1'b0;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_out;
    logic [TW-1:0] resp_tag;
`ifdef ALU_PIPE_ILLEGAL_OP_ERR_EN
    logic          resp_err;
`endif

    int checks = 0;
    int errors = 0;

    alu_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_tag   (resp_tag)
`ifdef ALU_PIPE_ILLEGAL_OP_ERR_EN
        ,
        .resp_err   (resp_err)
`endif
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] res;
        logic [TW-1:0] tag;
        logic          err;
        int            acc;
    } item_t;

    item_t q[$];
    item_t head;
    int    cyc = 0;
    logic  exp_ready;
    logic  exp_rvalid;

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        int unsigned s;
        logic [DW-1:0] ones;
        logic [DW-1:0] msb;
        s = b % DW;
        ones = '1;
        msb = '0;
        msb[DW-1] = 1'b1;
        case (op)
            4'd0:  return a << s;
            4'd1:  return a >> s;
            4'd2:  return (a >> s) | (a[DW-1] ? ~(ones >> s) : '0);
            4'd3:  return a + b;
            4'd4:  return a - b;
            4'd5:  return a & b;
            4'd6:  return a | b;
            4'd7:  return a ^ b;
            4'd10: return ((a ^ msb) < (b ^ msb)) ? 1 : 0;
            4'd11: return (a < b) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [3:0] op);
        return !((op <= 4'd7) || (op == 4'd10) || (op == 4'd11));
    endfunction

    // Capacity two: a new request fits unless two are held and none leaves.
    // The oldest item is always visible two cycles after acceptance.
    task automatic model_eval();
        exp_ready  = (q.size() < 2) || resp_ready;
        exp_rvalid = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
        if (q.size() > 0) head = q[0];
    endtask

    task automatic advance();
        item_t it;
        if (exp_rvalid && resp_ready) it = q.pop_front();
        if (req_valid && exp_ready) begin
            it.res = ref_alu(req_op, req_A, req_B);
            it.tag = req_tag;
            it.err = ref_ill(req_op);
            it.acc = cyc;
            q.push_back(it);
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [TW-1:0] tg, input logic rr);
        req_valid  = v;
        req_op     = op;
        req_A      = a;
        req_B      = b;
        req_tag    = tg;
        resp_ready = rr;
        #1;
        model_eval();
    endtask

    function automatic logic [DW-1:0] rnd_word();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        nRST = 1'b0;
        #2;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", resp_valid);
        end
        checks++;
        if (resp_out !== '0) begin
            errors++;
            $display("FAIL reset_out: got %h expected 0", resp_out);
        end
        checks++;
        if (resp_tag !== '0) begin
            errors++;
            $display("FAIL reset_tag: got %h expected 0", resp_tag);
        end
`ifdef ALU_PIPE_ILLEGAL_OP_ERR_EN
        checks++;
        if (resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b expected 0", resp_err);
        end
`endif
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        q.delete();
        drive(0, 0, 0, 0, 0, 1);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        advance();
    endtask

    task automatic test_add_latency();
        drive(1, 4'd3, 32'hFFFF_FFFF, 32'd1, 4'd3, 1);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_ready: got %b expected 1", req_ready);
        end
        advance();
        drive(0, 0, 0, 0, 0, 1);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_early: got valid %b expected 0", resp_valid);
        end
        advance();
        drive(0, 0, 0, 0, 0, 1);
        checks++;
        if (resp_valid !== 1'b1 || resp_out !== 32'h0 || resp_tag !== 4'd3) begin
            errors++;
            $display("FAIL add_result: got v=%b out=%h tag=%h expected v=1 out=0 tag=3",
                     resp_valid, resp_out, resp_tag);
        end
        advance();
    endtask

    task automatic test_sra_slt();
        logic [DW-1:0] want[3];
        logic [3:0]    ops[3];
        logic [DW-1:0] as[3];
        logic [DW-1:0] bs[3];
        int n = 0;
        want = '{32'hF800_0000, 32'd1, 32'd0};
        ops  = '{4'd2, 4'd10, 4'd11};
        as   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bs   = '{32'h0000_0024, 32'd1, 32'd1};
        for (int i = 0; i < 7; i++) begin
            if (i < 3) drive(1, ops[i], as[i], bs[i], 4'(i), 1);
            else drive(0, 0, 0, 0, 0, 1);
            if (resp_valid === 1'b1 && n < 3) begin
                checks++;
                if (resp_out !== want[n] || resp_tag !== 4'(n)) begin
                    errors++;
                    $display("FAIL sra_slt_%0d: got out=%h tag=%h expected out=%h tag=%0d",
                             n, resp_out, resp_tag, want[n], n);
                end
                n++;
            end
            advance();
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL sra_slt_count: got %0d responses expected 3", n);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int first = -1;
        int last = -1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive(1, 4'($urandom % 8), $urandom, $urandom, 4'(i), 1);
            else drive(0, 0, 0, 0, 0, 1);
            if (i < 8) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready: cycle %0d got %b expected 1", i, req_ready);
                end
            end
            checks++;
            if (resp_valid !== exp_rvalid) begin
                errors++;
                $display("FAIL b2b_valid: cycle %0d got %b expected %b",
                         i, resp_valid, exp_rvalid);
            end
            if (exp_rvalid) begin
                checks++;
                if (resp_tag !== 4'(n) || resp_out !== head.res) begin
                    errors++;
                    $display("FAIL b2b_data: got out=%h tag=%h expected out=%h tag=%0d",
                             resp_out, resp_tag, head.res, n);
                end
                if (first < 0) first = i;
                last = i;
                n++;
            end
            advance();
        end
        checks++;
        if (n != 8 || (last - first) != 7) begin
            errors++;
            $display("FAIL b2b_stream: got %0d responses over span %0d expected 8 over 7",
                     n, last - first);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'($urandom % 8), $urandom, $urandom, 4'(8 + i), 0);
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL bp_ready: cycle %0d got %b expected %b",
                         i, req_ready, exp_ready);
            end
            if (req_ready === 1'b1) acc++;
            checks++;
            if (resp_valid !== exp_rvalid) begin
                errors++;
                $display("FAIL bp_valid: cycle %0d got %b expected %b",
                         i, resp_valid, exp_rvalid);
            end
            if (exp_rvalid) begin
                checks++;
                if (resp_out !== head.res || resp_tag !== head.tag) begin
                    errors++;
                    $display("FAIL bp_hold: got out=%h tag=%h expected out=%h tag=%h",
                             resp_out, resp_tag, head.res, head.tag);
                end
            end
            advance();
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accepted: got %0d expected 2", acc);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            if (i == 0) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_release_ready: got %b expected 1", req_ready);
                end
            end
            checks++;
            if (resp_valid !== exp_rvalid) begin
                errors++;
                $display("FAIL bp_drain_valid: cycle %0d got %b expected %b",
                         i, resp_valid, exp_rvalid);
            end
            if (exp_rvalid) begin
                checks++;
                if (resp_tag !== 4'(8 + n) || resp_out !== head.res) begin
                    errors++;
                    $display("FAIL bp_drain: got out=%h tag=%h expected out=%h tag=%0d",
                             resp_out, resp_tag, head.res, 8 + n);
                end
                n++;
            end
            advance();
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d expected 2", n);
        end
    endtask

    task automatic test_illegal();
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1, 4'hC, 32'd5, 32'd7, 4'd9, 1);
            else drive(0, 0, 0, 0, 0, 1);
            if (resp_valid === 1'b1) begin
                checks++;
                if (resp_out !== '0 || resp_tag !== 4'd9) begin
                    errors++;
                    $display("FAIL illegal_out: got out=%h tag=%h expected out=0 tag=9",
                             resp_out, resp_tag);
                end
`ifdef ALU_PIPE_ILLEGAL_OP_ERR_EN
                checks++;
                if (resp_err !== 1'b1) begin
                    errors++;
                    $display("FAIL illegal_err: got %b expected 1", resp_err);
                end
`endif
                n++;
            end
            advance();
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL illegal_count: got %0d responses expected 1", n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i < 390) begin
                drive(($urandom % 4) != 0, 4'($urandom % 16), rnd_word(),
                      rnd_word(), 4'($urandom), ($urandom % 3) != 0);
            end else begin
                drive(0, 0, 0, 0, 0, 1);
            end
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_ready: cycle %0d got %b expected %b",
                         i, req_ready, exp_ready);
            end
            checks++;
            if (resp_valid !== exp_rvalid) begin
                errors++;
                $display("FAIL rnd_valid: cycle %0d got %b expected %b",
                         i, resp_valid, exp_rvalid);
            end
            if (exp_rvalid) begin
                checks++;
                if (resp_out !== head.res || resp_tag !== head.tag) begin
                    errors++;
                    $display("FAIL rnd_data: cycle %0d got out=%h tag=%h expected out=%h tag=%h",
                             i, resp_out, resp_tag, head.res, head.tag);
                end
`ifdef ALU_PIPE_ILLEGAL_OP_ERR_EN
                checks++;
                if (resp_err !== head.err) begin
                    errors++;
                    $display("FAIL rnd_err: cycle %0d got %b expected %b",
                             i, resp_err, head.err);
                end
`endif
            end
            advance();
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: got %0d left in flight expected 0", q.size());
        end
    endtask

    task automatic test_async_reset();
        drive(1, 4'd3, 32'd10, 32'd20, 4'd1, 0);
        advance();
        drive(1, 4'd6, 32'd3, 32'd4, 4'd2, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: got valid %b expected 1", resp_valid);
        end
        advance();
        nRST = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_out !== '0) begin
            errors++;
            $display("FAIL arst_now: got v=%b rdy=%b out=%h expected v=0 rdy=1 out=0",
                     resp_valid, req_ready, resp_out);
        end
        q.delete();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        cyc++;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) drive(1, 4'd4, 32'd1, 32'd2, 4'd5, 1);
            else drive(0, 0, 0, 0, 0, 1);
            checks++;
            if (resp_valid !== exp_rvalid) begin
                errors++;
                $display("FAIL arst_after: cycle %0d got valid %b expected %b",
                         i, resp_valid, exp_rvalid);
            end
            if (exp_rvalid) begin
                checks++;
                if (resp_out !== 32'hFFFF_FFFF || resp_tag !== 4'd5) begin
                    errors++;
                    $display("FAIL arst_first: got out=%h tag=%h expected out=ffffffff tag=5",
                             resp_out, resp_tag);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_sra_slt();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Param DATA_W, default 32, operand/result width.
REQ-002 Param TAG_W, default 4, request tag width, returned unchanged with result.
REQ-003 CLK  input  1  sole clock, all state on rising edge.
REQ-004 nRST  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block accepts request this cycle.
REQ-007 req_op  input  4  opcode: SLL=0, SRL=1, SRA=2, ADD=3, SUB=4, AND=5, OR=6, XOR=7, SLT=10, SLTU=11.
REQ-008 req_A  input  DATA_W  operand A.
REQ-009 req_B  input  DATA_W  operand B.
REQ-010 req_tag  input  TAG_W  request tag.
REQ-011 resp_valid  output  1  result present.
REQ-012 resp_ready  input  1  consumer accepts result this cycle.
REQ-013 resp_out  output  DATA_W  result.
REQ-014 resp_tag  output  TAG_W  tag of the request that produced resp_out.
REQ-015 resp_err  output  1  illegal opcode flag (present only per REQ-032).

Function
REQ-016 Two register stages: S0 (captured request: valid, op, A, B, tag) and S1 (computed result: valid, result, tag, err).
REQ-017 Request handshake completes when req_valid && req_ready; response handshake when resp_valid && resp_ready.
REQ-018 resp_valid, resp_out, resp_tag, resp_err driven directly from S1 registers.
REQ-019 S1 advance condition: !S1.valid || resp_ready; S1 loads S0 result when S0.valid and advance, clears valid when S0 empty and advance, holds otherwise.
REQ-020 req_ready = !S0.valid || S1 advance condition; combinational path from resp_ready to req_ready permitted, none from req_valid.
REQ-021 Unstalled latency: request accepted in cycle N gives resp_valid in cycle N+2; sustained throughput one op per cycle.
REQ-022 Under backpressure S0 and S1 hold all fields; no request dropped, duplicated or reordered; capacity two in flight.
REQ-023 Simultaneous response handshake and request accept with both stages full: all three advance in same cycle, no bubble.
REQ-024 Shifts use B[4:0] only (log2 DATA_W bits); SRA sign-fills from A[DATA_W-1].
REQ-025 ADD/SUB wrap modulo 2^DATA_W, no carry/overflow output.
REQ-026 SLT: result 1 if signed A < signed B else 0, zero-extended; SLTU same, unsigned.
REQ-027 Illegal opcodes (8, 9, 12-15): result 0, err 1; legal opcodes: err 0.
REQ-028 Output fields remain stable while resp_valid && !resp_ready.

Reset
REQ-029 nRST low forces S0.valid=0, S1.valid=0 immediately, independent of CLK.
REQ-030 Reset values: resp_valid 0, resp_out 0, resp_tag 0, resp_err 0, req_ready 1 (after reset).
REQ-031 Reset mid-operation discards all in-flight requests; first request after release obeys REQ-021.

Configuration
REQ-032 Macro ALU_PIPE_ILLEGAL_OP_ERR_EN: defined -> resp_err port exists and behaves per REQ-027; undefined -> port absent, illegal opcodes still produce result 0 and complete normally.

Verification
REQ-033 ADD A=0xFFFFFFFF B=1 tag=3, resp_ready=1 -> cycle N+2 resp_valid=1, resp_out=0x00000000, resp_tag=3.
REQ-034 SRA A=0x80000000 B=0x00000024; SLT A=0xFFFFFFFF B=1; SLTU same operands -> results 0xF8000000, 1, 0 in order.
REQ-035 Back-to-back 8 requests tags 0-7, resp_ready=1 -> 8 consecutive resp_valid cycles, tags 0-7 in order, req_ready never low.
REQ-036 resp_ready=0 for 5 cycles with req_valid=1 -> exactly 2 accepted, req_ready=0 from 3rd cycle, outputs stable; resp_ready=1 -> drains in order, req_ready=1 same cycle.
REQ-037 req_op=4'hC, A=5, B=7 -> resp_out=0, resp_err=1 with macro; resp_out=0, no err port without.
REQ-038 nRST low asynchronously with 2 in flight -> resp_valid=0 before next edge; after release no stale responses emitted.
